// File: rtl/bus_ctrl_pkg.sv
// Shared i8080 bus definitions: status bit positions, cycle states and the RST opcode template.
package bus_ctrl_pkg;

  localparam int unsigned ST_INTA  = 0;
  localparam int unsigned ST_WO_N  = 1;
  localparam int unsigned ST_STACK = 2;
  localparam int unsigned ST_HLTA  = 3;
  localparam int unsigned ST_OUT   = 4;
  localparam int unsigned ST_M1    = 5;
  localparam int unsigned ST_INP   = 6;
  localparam int unsigned ST_MEMR  = 7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [1:0] RST_PREFIX   = 2'b11;
  localparam logic [2:0] RST_SUFFIX   = 3'b111;
  localparam logic [2:0] SPURIOUS_IDX = 3'd7;

  // RST n instruction byte jammed onto the bus during interrupt acknowledge.
  function automatic logic [7:0] rst_opcode(input logic [2:0] idx);
    return {RST_PREFIX, idx, RST_SUFFIX};
  endfunction

endpackage

// File: rtl/bus_ctrl_irq_ctrl.sv
// Interrupt front end: request synchronisers, rising-edge pending latch and
// lowest-index priority encoder feeding the acknowledge vector.
module irq_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq,
  input  logic             inte,
  input  logic             ack_take,
  input  logic             ack_done,
  output logic [2:0]       ack_idx,
  output logic             iint
);

  logic [N_IRQ-1:0] meta_q, sync_q, prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] rise, clr_mask, avail;
  logic [2:0]       ack_idx_q, ack_idx_d, low_idx;
  logic             ack_valid_q, ack_valid_d;
  logic             any_avail;
  logic             iint_q;

  assign rise = sync_q & ~prev_q;

  // A spurious acknowledge leaves ack_valid low, so nothing is cleared.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr_mask[i] = ack_done & ack_valid_q & (ack_idx_q == 3'(i));
    end
  end

  assign avail     = pending_q & ~clr_mask;
  // A fresh edge in the clearing clock wins over the clear.
  assign pending_d = avail | rise;

  always_comb begin
    low_idx   = SPURIOUS_IDX;
    any_avail = 1'b0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (avail[i]) begin
        low_idx   = 3'(i);
        any_avail = 1'b1;
      end
    end
  end

  always_comb begin
    ack_idx_d   = ack_idx_q;
    ack_valid_d = ack_valid_q;
    if (ack_take) begin
      ack_idx_d   = low_idx;
      ack_valid_d = any_avail;
    end else if (ack_done) begin
      ack_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q      <= '0;
      sync_q      <= '0;
      prev_q      <= '0;
      pending_q   <= '0;
      ack_idx_q   <= '0;
      ack_valid_q <= 1'b0;
      iint_q      <= 1'b0;
    end else begin
      meta_q      <= irq;
      sync_q      <= meta_q;
      prev_q      <= sync_q;
      pending_q   <= pending_d;
      ack_idx_q   <= ack_idx_d;
      ack_valid_q <= ack_valid_d;
      iint_q      <= inte & (|pending_q);
    end
  end

  assign ack_idx = ack_idx_q;
  assign iint    = iint_q;

endmodule

// File: rtl/bus_ctrl.sv
// i8080 system controller: latches the status byte on sync, inserts wait
// states, decodes bus strobes and serves RST opcodes on interrupt acknowledge.
module bus_ctrl
  import bus_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 8,
  parameter int unsigned N_IRQ    = 8,
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned IO_WAIT  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic             dbin,
  input  logic             write_n,
  input  logic [XLEN-1:0]  data_in,
  input  logic             inte,
  input  logic [N_IRQ-1:0] irq,
  output logic [XLEN-1:0]  status,
  output logic             ready,
  output logic             iint,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             io_rd,
  output logic             io_wr,
  output logic             inta_rd,
  output logic [XLEN-1:0]  data_out,
  output logic             data_oe
);

  localparam logic [7:0] MEM_LOAD = 8'(MEM_WAIT);
  localparam logic [7:0] IO_LOAD  = 8'(IO_WAIT);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] status_q, status_d;
  logic [7:0]      cnt_q, cnt_d, load;
  logic            in_data, s_inta, s_inp, s_out, s_hlta, io;
  logic            ack_take, ack_done;
  logic [2:0]      ack_idx;

  // Wait-state count is chosen from the incoming status byte.
  always_comb begin
    if (data_in[ST_HLTA]) begin
      load = 8'd0;
    end else if (data_in[ST_INP] | data_in[ST_OUT] | data_in[ST_INTA]) begin
      load = IO_LOAD;
    end else begin
      load = MEM_LOAD;
    end
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    cnt_d    = cnt_q;
    if (sync) begin
      status_d = data_in;
      cnt_d    = load;
      state_d  = (load != 8'd0) ? S_WAIT : S_DATA;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 8'd1;
      if (cnt_q == 8'd1) begin
        state_d = S_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      status_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_data = (state_q == S_DATA);
  assign s_inta  = status_q[ST_INTA];
  assign s_inp   = status_q[ST_INP];
  assign s_out   = status_q[ST_OUT];
  assign s_hlta  = status_q[ST_HLTA];
  assign io      = s_inp | s_out;

  always_comb begin
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    io_rd   = 1'b0;
    io_wr   = 1'b0;
    inta_rd = 1'b0;
    if (in_data && !s_hlta) begin
      mem_rd  = dbin & ~io & ~s_inta;
      mem_wr  = ~write_n & ~io & ~s_inta;
      io_rd   = dbin & s_inp;
      io_wr   = ~write_n & s_out;
      inta_rd = dbin & s_inta;
    end
  end

  always_comb begin
    data_out = '0;
    data_oe  = 1'b0;
    if (in_data && s_inta) begin
      data_out = XLEN'(rst_opcode(ack_idx));
      data_oe  = dbin;
    end
  end

  // The sync following an INTA cycle retires the acknowledged request.
  assign ack_take = sync & data_in[ST_INTA];
  assign ack_done = sync & s_inta & (state_q != S_IDLE);

  irq_ctrl #(
    .N_IRQ(N_IRQ)
  ) u_irq_ctrl (
    .clk      (clk),
    .rst      (rst),
    .irq      (irq),
    .inte     (inte),
    .ack_take (ack_take),
    .ack_done (ack_done),
    .ack_idx  (ack_idx),
    .iint     (iint)
  );

  assign status = status_q;
  assign ready  = (state_q != S_WAIT);

endmodule

// File: tb/tb_bus_ctrl.sv
// Self-checking bench for bus_ctrl: table of bus cycles through a scoreboard
// plus hand-written interrupt and reset sequences.
module tb_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sync = 1'b0;
  logic       dbin = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       inte = 1'b0;
  logic [7:0] irq = 8'h00;
  logic [7:0] status, data_out;
  logic       ready, iint, mem_rd, mem_wr, io_rd, io_wr, inta_rd, data_oe;
  logic [4:0] strb;

  bus_ctrl #(
    .XLEN     (8),
    .N_IRQ    (8),
    .MEM_WAIT (0),
    .IO_WAIT  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sync     (sync),
    .dbin     (dbin),
    .write_n  (write_n),
    .data_in  (data_in),
    .inte     (inte),
    .irq      (irq),
    .status   (status),
    .ready    (ready),
    .iint     (iint),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .inta_rd  (inta_rd),
    .data_out (data_out),
    .data_oe  (data_oe)
  );

  always #5 clk = ~clk;

  assign strb = {mem_rd, mem_wr, io_rd, io_wr, inta_rd};

  typedef struct {
    logic [7:0] st;
    logic       dbin;
    logic       wr_n;
    int         waits;
    logic [4:0] strb;
    logic [7:0] dout;
    logic       oe;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] st, input logic db, input logic wn,
                              input int waits, input logic [4:0] s, input logic [7:0] dout,
                              input logic oe);
    vec_t v;
    v.st = st; v.dbin = db; v.wr_n = wn; v.waits = waits;
    v.strb = s; v.dout = dout; v.oe = oe;
    return v;
  endfunction

  task automatic start_cycle(input vec_t v);
    @(negedge clk);
    sync    = 1'b1;
    data_in = v.st;
    dbin    = 1'b0;
    write_n = 1'b1;
    sb.push_back(v);
  endtask

  task automatic finish_cycle(input vec_t v);
    vec_t e;
    int   n;
    @(negedge clk);
    sync    = 1'b0;
    dbin    = v.dbin;
    write_n = v.wr_n;
    #1;
    n = 0;
    while (ready !== 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      #1;
    end
    e = sb.pop_front();
    chk($sformatf("waits[%h]", e.st), n, e.waits);
    chk($sformatf("status[%h]", e.st), status, e.st);
    chk($sformatf("strobes[%h]", e.st), strb, e.strb);
    chk($sformatf("data_out[%h]", e.st), data_out, e.dout);
    chk($sformatf("data_oe[%h]", e.st), data_oe, e.oe);
  endtask

  task automatic run_cycle(input vec_t v);
    start_cycle(v);
    finish_cycle(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // strobe order {mem_rd, mem_wr, io_rd, io_wr, inta_rd}
    tbl[0]  = mk(8'h82, 1, 1, 0, 5'b10000, 8'h00, 0);
    tbl[1]  = mk(8'h00, 0, 0, 0, 5'b01000, 8'h00, 0);
    tbl[2]  = mk(8'h10, 0, 0, 2, 5'b00010, 8'h00, 0);
    tbl[3]  = mk(8'h42, 1, 1, 2, 5'b00100, 8'h00, 0);
    tbl[4]  = mk(8'h8A, 1, 1, 0, 5'b00000, 8'h00, 0);
    tbl[5]  = mk(8'hA2, 1, 1, 0, 5'b10000, 8'h00, 0);
    tbl[6]  = mk(8'h86, 1, 1, 0, 5'b10000, 8'h00, 0);
    tbl[7]  = mk(8'h04, 0, 0, 0, 5'b01000, 8'h00, 0);
    tbl[8]  = mk(8'h10, 1, 1, 2, 5'b00000, 8'h00, 0);
    tbl[9]  = mk(8'h23, 1, 1, 2, 5'b00001, 8'hFF, 1);
    tbl[10] = mk(8'h23, 0, 1, 2, 5'b00000, 8'hFF, 0);

    // Reset state, with read/write strobes requested to prove gating.
    #1 rst = 1'b1;
    dbin    = 1'b1;
    write_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready", ready, 1'b1);
    chk("rst iint", iint, 1'b0);
    chk("rst strobes", strb, 5'b0);
    chk("rst status", status, 8'h00);
    chk("rst data_out", data_out, 8'h00);
    chk("rst data_oe", data_oe, 1'b0);
    @(negedge clk);
    rst     = 1'b0;
    dbin    = 1'b0;
    write_n = 1'b1;
    inte    = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_cycle(tbl[i]);
    end
    #1 chk("spurious leaves iint", iint, 1'b0);

    // Two requests; lowest index acknowledged first.
    @(negedge clk);
    irq[5] = 1'b1;
    repeat (2) @(negedge clk);
    irq[5] = 1'b0;
    irq[2] = 1'b1;
    repeat (2) @(negedge clk);
    irq[2] = 1'b0;
    repeat (4) @(negedge clk);
    #1 chk("iint raised", iint, 1'b1);
    run_cycle(mk(8'h23, 1, 1, 2, 5'b00001, 8'hD7, 1));
    run_cycle(mk(8'h82, 1, 1, 0, 5'b10000, 8'h00, 0));
    run_cycle(mk(8'h23, 1, 1, 2, 5'b00001, 8'hEF, 1));
    run_cycle(mk(8'h82, 1, 1, 0, 5'b10000, 8'h00, 0));
    repeat (4) @(negedge clk);
    #1 chk("iint after both acks", iint, 1'b0);

    // New edge on irq[0] lands in the same clock as its clear.
    irq[0] = 1'b1;
    repeat (3) @(negedge clk);
    irq[0] = 1'b0;
    repeat (4) @(negedge clk);
    run_cycle(mk(8'h23, 1, 1, 2, 5'b00001, 8'hC7, 1));
    irq[0] = 1'b1;
    @(negedge clk);
    run_cycle(mk(8'h82, 1, 1, 0, 5'b10000, 8'h00, 0));
    repeat (3) @(negedge clk);
    #1 chk("iint kept by edge", iint, 1'b1);
    run_cycle(mk(8'h23, 1, 1, 2, 5'b00001, 8'hC7, 1));
    run_cycle(mk(8'h82, 1, 1, 0, 5'b10000, 8'h00, 0));
    irq = 8'h00;
    repeat (4) @(negedge clk);
    #1 chk("iint after re-ack", iint, 1'b0);

    // Reset in the middle of a wait state.
    @(negedge clk);
    sync    = 1'b1;
    data_in = 8'h10;
    @(negedge clk);
    sync    = 1'b0;
    write_n = 1'b0;
    dbin    = 1'b1;
    #1 chk("pre-rst ready", ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid-rst ready", ready, 1'b1);
    chk("mid-rst strobes", strb, 5'b0);
    chk("mid-rst status", status, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-rst strobes %0d", i), strb, 5'b0);
      chk($sformatf("post-rst ready %0d", i), ready, 1'b1);
    end
    run_cycle(mk(8'h82, 1, 1, 0, 5'b10000, 8'h00, 0));
    run_cycle(mk(8'h10, 0, 0, 2, 5'b00010, 8'h00, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_ctrl.md
BUS_CTRL -- requirements
Module: bus_ctrl

Interface
REQ-001 Parameter XLEN, default 8: data/status width.
REQ-002 Parameter N_IRQ, default 8, legal 1..8: interrupt request lines.
REQ-003 Parameter MEM_WAIT, default 0: wait states inserted on memory cycles.
REQ-004 Parameter IO_WAIT, default 1: wait states inserted on INP/OUT/INTA cycles.
REQ-005 clk  input  1  single clock.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 sync  input  1  CPU status-strobe cycle.
REQ-008 dbin  input  1  CPU read strobe.
REQ-009 write_n  input  1  CPU write strobe, active-low.
REQ-010 data_in  input  XLEN  CPU data bus, observed.
REQ-011 inte  input  1  CPU interrupt-enable flag.
REQ-012 irq  input  N_IRQ  interrupt requests; index 0 highest priority.
REQ-013 status  output  XLEN  latched status byte.
REQ-014 ready  output  1  CPU ready.
REQ-015 iint  output  1  interrupt request to CPU.
REQ-016 mem_rd, mem_wr, io_rd, io_wr, inta_rd  output  1 each  decoded strobes.
REQ-017 data_out  output  XLEN  RST opcode for the interrupt-acknowledge cycle.
REQ-018 data_oe  output  1  drive enable for data_out.

Function
REQ-019 Status bits SHALL be INTA=0, WO_N=1, STACK=2, HLTA=3, OUT=4, M1=5, INP=6, MEMR=7.
REQ-020 On every clk edge with sync=1: status <= data_in; wait counter loaded; state updated per REQ-022; this SHALL occur regardless of the current state.
REQ-021 Counter load value SHALL be IO_WAIT if status INP|OUT|INTA, else MEM_WAIT; HLTA cycles SHALL load 0.
REQ-022 States IDLE, WAIT, DATA; sync -> WAIT if load>0, else DATA; WAIT decrements each non-sync clk and -> DATA when it reaches 0; DATA holds until the next sync.
REQ-023 ready SHALL be 0 exactly in WAIT and 1 otherwise, giving N wait cycles for load value N.
REQ-024 Strobes SHALL assert only in DATA: mem_rd=dbin&~io&~INTA; mem_wr=~write_n&~io&~INTA; io_rd=dbin&INP; io_wr=~write_n&OUT; inta_rd=dbin&INTA; io=INP|OUT; all 0 on HLTA.
REQ-025 irq SHALL pass through a 2-flop synchroniser; a 0->1 edge of the synchronised line sets pending[i].
REQ-026 iint SHALL equal inte & |pending, registered.
REQ-027 On sync capturing INTA, ack_idx SHALL latch the lowest-index set pending bit; with none set, ack_idx=7 (spurious).
REQ-028 While in DATA with INTA: data_out SHALL be {2'b11, ack_idx[2:0], 3'b111}, zero-extended/truncated to XLEN; data_oe=dbin; otherwise data_oe=0 and data_out=0.
REQ-029 pending[ack_idx] SHALL clear on the sync that ends the INTA cycle; a new edge on the same line in that clock SHALL win (bit stays set).
REQ-030 A spurious acknowledge SHALL clear no pending bit.

Reset
REQ-031 rst SHALL force: state IDLE, status 0, counter 0, pending 0, synchronisers 0, ack_idx 0, ready 1, iint 0, all strobes 0, data_oe 0, data_out 0.
REQ-032 rst asserted mid-cycle SHALL abort it immediately; the first cycle after release SHALL begin only at the next sync.

Structure
REQ-033 Status bit positions and the RST opcode template SHALL live in the shared i8080 header/package.
REQ-034 The priority encoder plus pending register SHALL be one sub-module, irq_ctrl.

Verification
REQ-035 MEM_WAIT=0: sync with data_in=8'h82 (MEMR|WO_N), then dbin=1 -> ready stays 1, mem_rd=1 in the following cycle.
REQ-036 IO_WAIT=2: sync with 8'h10 (OUT), write_n=0 -> ready=0 for exactly 2 cycles, then io_wr=1; mem_wr stays 0.
REQ-037 irq[5] then irq[2] pulse, inte=1 -> iint=1; INTA cycle (8'h23) with dbin=1 -> data_out=8'hD7, data_oe=1; the next sync clears pending[2] only; the second INTA returns 8'hEF.
REQ-038 INTA with pending=0 -> data_out=8'hFF; pending stays 0.
REQ-039 rst pulse during WAIT -> ready=1, strobes 0 and state IDLE immediately; no strobe until the next sync.
REQ-040 irq[0] edge coinciding with the clear of pending[0] -> pending[0] remains 1; iint stays 1.
